// File: rtl/wide_add_sequencer.sv
// Multi-cycle W = N*WORDS-bit adder built from one N-bit adder.
// Chunks are processed LSB first and the carry is chained through a register.

module adder_n_bit #(
    parameter int N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         c_in,
    output logic [N-1:0] sum,
    output logic         c_out
);
    assign {c_out, sum} = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, c_in};
endmodule

module wide_add_sequencer #(
    parameter int N     = 8,
    parameter int WORDS = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [N*WORDS-1:0] a,
    input  logic [N*WORDS-1:0] b,
    input  logic               c_in,
    output logic               busy,
    output logic               done,
    output logic [N*WORDS-1:0] sum,
    output logic               c_out
);
    localparam int W  = N * WORDS;
    localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic [W-1:0]    r_sum;
    logic            r_carry;
    logic            r_cout;
    logic [IW-1:0]   r_idx;
    logic [N-1:0]    w_chunk_a;
    logic [N-1:0]    w_chunk_b;
    logic [N-1:0]    w_add_sum;
    logic            w_add_cout;
    logic            w_last;

    assign w_chunk_a = r_a[r_idx*N +: N];
    assign w_chunk_b = r_b[r_idx*N +: N];
    assign w_last    = (r_idx == IW'(WORDS - 1));

    adder_n_bit #(.N(N)) u_adder (
        .a     (w_chunk_a),
        .b     (w_chunk_b),
        .c_in  (r_carry),
        .sum   (w_add_sum),
        .c_out (w_add_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_RUN;
            S_RUN:   if (w_last) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state == S_RUN);
        done = (r_state == S_DONE);
    end

    // idx wraps to 0 on the last chunk so it never exceeds WORDS-1.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_idx   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_carry <= c_in;
                        r_idx   <= '0;
                    end
                end
                S_RUN: begin
                    r_sum[r_idx*N +: N] <= w_add_sum;
                    r_carry             <= w_add_cout;
                    r_idx               <= w_last ? '0 : r_idx + IW'(1);
                    if (w_last) r_cout <= w_add_cout;
                end
                default: ;
            endcase
        end
    end

    assign sum   = r_sum;
    assign c_out = r_cout;
endmodule

// File: tb/tb_wide_add_sequencer.sv
// Scoreboard bench for wide_add_sequencer: driver pushes expected {c_out,sum},
// monitor pops on every done pulse and also checks busy length and done width.

module tb_wide_add_sequencer;
    localparam int N     = 8;
    localparam int WORDS = 4;
    localparam int W     = N * WORDS;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c_in;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         c_out;

    int n_checks = 0;
    int n_fail   = 0;
    logic [W:0] sb[$];

    wide_add_sequencer #(.N(N), .WORDS(WORDS)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .c_in  (c_in),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .c_out (c_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W:0] act, input logic [W:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
        return {1'b0, x} + {1'b0, y} + (W+1)'(ci);
    endfunction

    // Monitor: result check, busy run length and single-cycle done.
    int   busy_cnt  = 0;
    logic prev_done = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            busy_cnt  = 0;
            prev_done = 1'b0;
        end else begin
            if (busy) busy_cnt++;
            if (done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    check("result", {c_out, sum}, sb.pop_front());
                end
                check("busy_cycles", (W+1)'(busy_cnt), (W+1)'(WORDS));
                check("done_width", (W+1)'(prev_done), '0);
                busy_cnt = 0;
            end
            prev_done = done;
        end
    end

    task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
        @(posedge clk); #1;
        a = x; b = y; c_in = ci; start = 1'b1;
        sb.push_back(model(x, y, ci));
    endtask

    // Waits for done (bounded); optionally scrambles inputs while running.
    task automatic wait_done(input bit junk, input string name);
        bit seen = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done) begin
                seen = 1;
                break;
            end
            if (junk) begin
                start = 1'($urandom);
                a = $urandom; b = $urandom; c_in = 1'($urandom);
            end
        end
        start = 1'b0;
        if (!seen) check({name, "_timeout"}, 0, 1);
    endtask

    task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci,
                         input bit junk, input string name);
        issue(x, y, ci);
        @(posedge clk); #1;
        start = 1'b0;
        if (junk) begin a = $urandom; b = $urandom; c_in = 1'($urandom); end
        wait_done(junk, name);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; a = '0; b = '0; c_in = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_state", {busy, done, sum, c_out}, '0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Directed cases
        do_op(32'hFFFFFFFF, 32'h00000001, 1'b0, 0, "carry_ripple");
        do_op(32'h12345678, 32'h11111111, 1'b0, 0, "no_carry");
        do_op(32'h55555555, 32'hAAAAAAAA, 1'b1, 0, "carry_in");
        do_op(32'h00000000, 32'h00000000, 1'b1, 0, "cin_zero");

        // Start held during RUN/DONE is ignored; next op accepted once back in IDLE
        issue(32'h000000FF, 32'h00000001, 1'b0);
        @(posedge clk); #1;
        a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; c_in = 1'b0;
        sb.push_back(model(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0));
        begin
            bit seen = 0;
            for (int k = 0; k < 20; k++) begin
                @(negedge clk);
                if (done) begin seen = 1; break; end
            end
            if (!seen) check("held_start_timeout", 0, 1);
        end
        @(negedge clk);
        check("held_idle_after_done", {busy, done}, '0);
        @(negedge clk);
        check("held_accept", (W+1)'(busy), 1);
        start = 1'b0;
        wait_done(0, "held_second");

        // Reset mid-operation
        issue(32'hFFFFFFFF, 32'h00000001, 1'b0);
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sb.delete();
        @(negedge clk);
        check("abort_state", {busy, done, sum, c_out}, '0);
        repeat (8) @(negedge clk);
        do_op(32'h00000003, 32'h00000004, 1'b0, 0, "after_abort");

        // Randomized ops with inputs scrambled while busy
        for (int i = 0; i < 40; i++) begin
            do_op($urandom, $urandom, 1'($urandom), 1, "random");
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end
        // Edge operands
        do_op('1, '1, 1'b1, 0, "all_ones");
        do_op('0, '0, 1'b0, 0, "all_zero");

        repeat (4) @(posedge clk);
        check("scoreboard_empty", (W+1)'(sb.size()), '0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
